// File: rtl/lvds_rx_pkg.sv
// Shared constants and state type for the LVDS receive frame aligner.
package lvds_rx_pkg;

    localparam int unsigned DESER_FACTOR  = 6;
    localparam int unsigned NR_DATA_LANES = 8;
    localparam int unsigned FRAME_LANE    = NR_DATA_LANES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED
    } align_state_e;

endpackage

// File: rtl/lvds_rx_lock_sync.sv
// Two-flop synchronizer bringing the deserializer PLL lock into rx_clk.
module lvds_rx_lock_sync (
    input  logic rx_clk,
    input  logic reset,
    input  logic rx_locked,
    output logic lock_s
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values of the synchronizer chain.
    always_comb begin
        meta_d = rx_locked;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared by reset.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign lock_s = sync_q;

endmodule

// File: rtl/lvds_rx_frame_align.sv
// Frame-lane word aligner: bit-slips the deserializer until the frame lane
// shows FRAME_PATTERN, then presents the data lanes as valid.
// Optional statistics counters (slip_count, err_count) are built only when
// LVDS_RX_ALIGN_STATS_EN is defined; otherwise both outputs are tied to 0.
module lvds_rx_frame_align #(
    parameter int unsigned               DESER_FACTOR  = lvds_rx_pkg::DESER_FACTOR,
    parameter int unsigned               NR_DATA_LANES = lvds_rx_pkg::NR_DATA_LANES,
    parameter logic [DESER_FACTOR-1:0]   FRAME_PATTERN = 6'b111000,
    parameter int unsigned               MATCH_CNT     = 4,
    parameter int unsigned               SETTLE_CYCLES = 8,
    parameter int unsigned               MAX_ERR       = 3
) (
    input  logic                                         rx_clk,
    input  logic                                         reset,
    input  logic                                         rx_locked,
    input  logic [(NR_DATA_LANES+1)*DESER_FACTOR-1:0]    rx_data,
    output logic                                         rx_data_align,
    output logic [NR_DATA_LANES*DESER_FACTOR-1:0]        data_out,
    output logic                                         data_valid,
    output logic                                         align_fail,
    output logic [7:0]                                   slip_count,
    output logic [15:0]                                  err_count
);

    import lvds_rx_pkg::*;

    localparam int unsigned DW = NR_DATA_LANES * DESER_FACTOR;
    localparam int unsigned MW = $clog2(MATCH_CNT + 1);
    localparam int unsigned EW = $clog2(MAX_ERR + 1);
    localparam int unsigned SW = $clog2(DESER_FACTOR + 1);
    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 2);

    logic                    lock_s;
    logic [DESER_FACTOR-1:0] frame_word;
    logic                    frame_match;

    align_state_e  state_q, state_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d;
    logic [EW-1:0] err_run_q, err_run_d;
    logic [SW-1:0] search_slips_q, search_slips_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          align_fail_q, align_fail_d;
    logic          rx_data_align_q, rx_data_align_d;
    logic          data_valid_q, data_valid_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          slip_evt;

    lvds_rx_lock_sync u_lock_sync (
        .rx_clk    (rx_clk),
        .reset     (reset),
        .rx_locked (rx_locked),
        .lock_s    (lock_s)
    );

    assign frame_word  = rx_data[NR_DATA_LANES*DESER_FACTOR +: DESER_FACTOR];
    assign frame_match = (frame_word == FRAME_PATTERN);

    // Alignment search/track state machine and its counters.
    always_comb begin
        state_d        = state_q;
        match_cnt_d    = match_cnt_q;
        err_run_d      = err_run_q;
        search_slips_d = search_slips_q;
        cyc_d          = cyc_q;
        align_fail_d   = align_fail_q;
        slip_evt       = 1'b0;

        if (!lock_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (frame_match) begin
                        if (match_cnt_q == MW'(MATCH_CNT - 1)) begin
                            state_d = ST_LOCKED;
                        end else begin
                            match_cnt_d = match_cnt_q + MW'(1);
                        end
                    end else begin
                        state_d  = ST_SLIP;
                        slip_evt = 1'b1;
                    end
                end
                ST_SLIP: begin
                    if (cyc_q == CW'(1)) begin
                        state_d = ST_SETTLE;
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cyc_q == CW'(SETTLE_CYCLES - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (frame_match) begin
                        err_run_d = '0;
                    end else if (err_run_q == EW'(MAX_ERR - 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        err_run_d = err_run_q + EW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Every state change starts its local counters from zero.
        if (state_d != state_q) begin
            cyc_d       = '0;
            match_cnt_d = '0;
            err_run_d   = '0;
        end

        // A successful lock ends the search and clears the failure flag.
        if ((state_d == ST_LOCKED) && (state_q != ST_LOCKED)) begin
            search_slips_d = '0;
            align_fail_d   = 1'b0;
        end

        if (state_d == ST_IDLE) begin
            search_slips_d = '0;
        end

        // A full rotation of slips without lock flags failure; search continues.
        if (slip_evt) begin
            if (search_slips_q == SW'(DESER_FACTOR - 1)) begin
                search_slips_d = '0;
                align_fail_d   = 1'b1;
            end else begin
                search_slips_d = search_slips_q + SW'(1);
            end
        end

        rx_data_align_d = (state_d == ST_SLIP);
        data_valid_d    = (state_d == ST_LOCKED);
        data_out_d      = rx_data[DW-1:0];
    end

    // State, counters and registered outputs.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            match_cnt_q     <= '0;
            err_run_q       <= '0;
            search_slips_q  <= '0;
            cyc_q           <= '0;
            align_fail_q    <= 1'b0;
            rx_data_align_q <= 1'b0;
            data_valid_q    <= 1'b0;
            data_out_q      <= '0;
        end else begin
            state_q         <= state_d;
            match_cnt_q     <= match_cnt_d;
            err_run_q       <= err_run_d;
            search_slips_q  <= search_slips_d;
            cyc_q           <= cyc_d;
            align_fail_q    <= align_fail_d;
            rx_data_align_q <= rx_data_align_d;
            data_valid_q    <= data_valid_d;
            data_out_q      <= data_out_d;
        end
    end

    assign rx_data_align = rx_data_align_q;
    assign data_valid    = data_valid_q;
    assign data_out      = data_out_q;
    assign align_fail    = align_fail_q;

`ifdef LVDS_RX_ALIGN_STATS_EN
    logic        err_evt;
    logic [7:0]  slip_count_q, slip_count_d;
    logic [15:0] err_count_q, err_count_d;

    assign err_evt = lock_s && (state_q == ST_LOCKED) && !frame_match;

    // Saturating totals of slips issued and mismatches seen while locked.
    always_comb begin
        slip_count_d = slip_count_q;
        err_count_d  = err_count_q;
        if (slip_evt && (slip_count_q != 8'hFF)) begin
            slip_count_d = slip_count_q + 8'd1;
        end
        if (err_evt && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            slip_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            slip_count_q <= slip_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign slip_count = slip_count_q;
    assign err_count  = err_count_q;
`else
    assign slip_count = '0;
    assign err_count  = '0;
`endif

endmodule

// File: tb/tb_lvds_rx_frame_align.sv
// Self-checking bench for lvds_rx_frame_align: directed scenarios plus a
// randomized deserializer with a bit-rotating frame lane, compared cycle by
// cycle against a behavioural model of the alignment rules.
module tb_lvds_rx_frame_align;

    localparam int SETTLE = 8;
    localparam int MATCH  = 4;
    localparam int MAXE   = 3;
    localparam int DESER  = 6;
`ifdef LVDS_RX_ALIGN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        rx_locked;
    logic [53:0] rx_data;
    logic        rx_data_align;
    logic [47:0] data_out;
    logic        data_valid;
    logic        align_fail;
    logic [7:0]  slip_count;
    logic [15:0] err_count;

    logic [5:0] pat;
    logic [5:0] bad_word;

    int errs;
    int checks;
    int pulses;
    bit prev_align;
    bit slip_seen;

    // Model: alignment rules expressed as hunt/blackout/lock bookkeeping.
    bit [1:0]    m_hist;
    bit          m_armed;
    bit          m_locked;
    int          m_blackout;
    int          m_good;
    int          m_bad;
    int          m_search;
    bit          m_fail;
    int          m_slip_total;
    int          m_err_total;
    logic [47:0] m_dout;

    lvds_rx_frame_align dut (
        .rx_clk        (clk),
        .reset         (rst),
        .rx_locked     (rx_locked),
        .rx_data       (rx_data),
        .rx_data_align (rx_data_align),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .align_fail    (align_fail),
        .slip_count    (slip_count),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, exp finish before 200us");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] rotl6(input logic [5:0] w, input int p);
        logic [11:0] t;
        t = {w, w} << p;
        return t[11:6];
    endfunction

    task automatic model_reset();
        m_hist       = 2'b00;
        m_armed      = 1'b0;
        m_locked     = 1'b0;
        m_blackout   = 0;
        m_good       = 0;
        m_bad        = 0;
        m_search     = 0;
        m_fail       = 1'b0;
        m_slip_total = 0;
        m_err_total  = 0;
        m_dout       = '0;
    endtask

    task automatic model_edge();
        bit ls;
        bit hit;
        ls     = m_hist[1];
        m_hist = {m_hist[0], rx_locked};
        hit    = (rx_data[53:48] == pat);
        m_dout = rx_data[47:0];
        if (!ls) begin
            m_armed    = 1'b0;
            m_locked   = 1'b0;
            m_blackout = 0;
            m_good     = 0;
            m_bad      = 0;
            m_search   = 0;
        end else if (!m_armed) begin
            m_armed = 1'b1;
        end else if (m_blackout > 0) begin
            m_blackout--;
        end else if (m_locked) begin
            if (hit) begin
                m_bad = 0;
            end else begin
                if (m_err_total < 65535) m_err_total++;
                m_bad++;
                if (m_bad == MAXE) begin
                    m_locked = 1'b0;
                    m_bad    = 0;
                    m_good   = 0;
                end
            end
        end else begin
            if (hit) begin
                m_good++;
                if (m_good == MATCH) begin
                    m_locked = 1'b1;
                    m_good   = 0;
                    m_bad    = 0;
                    m_search = 0;
                    m_fail   = 1'b0;
                end
            end else begin
                m_good     = 0;
                m_blackout = 2 + SETTLE;
                if (m_slip_total < 255) m_slip_total++;
                m_search++;
                if (m_search == DESER) begin
                    m_search = 0;
                    m_fail   = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("align", 64'(rx_data_align), 64'(m_blackout > SETTLE));
        chk("valid", 64'(data_valid), 64'(m_locked));
        chk("fail",  64'(align_fail), 64'(m_fail));
        chk("dout",  64'(data_out), 64'(m_dout));
        chk("slips", 64'(slip_count), STATS ? 64'(m_slip_total) : 64'd0);
        chk("errs",  64'(err_count), STATS ? 64'(m_err_total) : 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        slip_seen  = rx_data_align && !prev_align;
        if (slip_seen) pulses++;
        prev_align = rx_data_align;
    endtask

    task automatic drive(input logic [5:0] fw);
        rx_data = {fw, 48'({$urandom, $urandom})};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        pulses     = 0;
        prev_align = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int  phase;
        int  drop_left;
        bit  found;
        logic [5:0] fw;

        errs      = 0;
        checks    = 0;
        pat       = 6'b111000;
        bad_word  = 6'b000111;
        rst       = 1'b1;
        rx_locked = 1'b1;
        rx_data   = '0;
        model_reset();

        // Aligned from the start: lock with no slip.
        drive(pat);
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            drive(pat);
            step();
            if (c == 8) chk("lock_by_8", 64'(data_valid), 64'd1);
        end
        chk("no_pulse", 64'(pulses), 64'd0);

        // Two slips needed before the frame lane lines up.
        drive(6'b110001);
        do_reset();
        for (int c = 0; c < 50; c++) begin
            drive((pulses < 2) ? 6'b110001 : pat);
            step();
        end
        chk("two_pulses", 64'(pulses), 64'd2);
        chk("two_lock", 64'(data_valid), 64'd1);
        chk("two_slipcnt", 64'(slip_count), STATS ? 64'd2 : 64'd0);

        // Never matching: failure flag after a full rotation, slipping continues.
        drive(bad_word);
        do_reset();
        for (int c = 0; c < 75; c++) begin
            drive(bad_word);
            step();
        end
        chk("fail_set", 64'(align_fail), 64'd1);
        chk("six_pulses", 64'(pulses >= 6), 64'd1);
        for (int c = 0; c < 20; c++) begin
            drive(bad_word);
            step();
        end
        chk("still_slip", 64'(pulses >= 7), 64'd1);
        for (int c = 0; c < 25; c++) begin
            drive(pat);
            step();
        end
        chk("relock", 64'(data_valid), 64'd1);
        chk("fail_clr", 64'(align_fail), 64'd0);

        // Error tolerance while locked.
        drive(bad_word); step();
        drive(bad_word); step();
        drive(pat);      step();
        chk("tol_valid", 64'(data_valid), 64'd1);
        chk("tol_errcnt", 64'(err_count), STATS ? 64'd2 : 64'd0);
        for (int c = 0; c < 3; c++) begin
            drive(bad_word);
            step();
        end
        chk("drop_valid", 64'(data_valid), 64'd0);
        for (int c = 0; c < 8; c++) begin
            drive(pat);
            step();
        end
        chk("back_lock", 64'(data_valid), 64'd1);

        // Lock loss while settling.
        drive(bad_word);
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(bad_word);
            step();
        end
        rx_locked = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(bad_word);
            step();
        end
        chk("settle_drop_valid", 64'(data_valid), 64'd0);
        chk("settle_drop_align", 64'(rx_data_align), 64'd0);

        // Reset in the middle of a slip pulse.
        rx_locked = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            drive(bad_word);
            step();
            if (rx_data_align) found = 1'b1;
        end
        chk("slip_reached", 64'(found), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_align", 64'(rx_data_align), 64'd0);
        chk("rst_valid", 64'(data_valid), 64'd0);
        chk("rst_dout",  64'(data_out), 64'd0);
        chk("rst_fail",  64'(align_fail), 64'd0);
        chk("rst_slips", 64'(slip_count), 64'd0);
        chk("rst_errs",  64'(err_count), 64'd0);
        do_reset();

        // Randomized deserializer with rotating frame lane, glitches and lock drops.
        phase     = 3;
        drop_left = 0;
        for (int c = 0; c < 600; c++) begin
            if (drop_left > 0) begin
                drop_left--;
                rx_locked = (drop_left == 0);
            end else if ($urandom_range(0, 199) == 0) begin
                rx_locked = 1'b0;
                drop_left = int'($urandom_range(2, 8));
            end
            fw = rotl6(pat, phase);
            if ($urandom_range(0, 29) == 0) fw = 6'($urandom);
            drive(fw);
            step();
            if (slip_seen) phase = (phase + 1) % DESER;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
